uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 132 +++++++++++++
 tb/tb_uart_receiver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8-bit UART receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Each bit is sampled at its centre. Results are published one cycle after the stop sample.
module uart_receiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TICKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF          = TICKS_PER_BIT / 2;
    localparam int TW            = $clog2(TICKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          rx_m, rx_s, rx_p;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          stop_bad;
    logic          done;

    // Synchronizer flops and the edge-detect copy reset high so that release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            stop_bad   <= 1'b0;
            done       <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Publish the finished frame. The shift register is safe here because
            // a new frame cannot sample a data bit this early.
            rx_valid <= done;
            done     <= 1'b0;
            if (done) begin
                rx_data    <= shift;
                parity_err <= par_bit ^ (^shift);
                frame_err  <= stop_bad;
            end

            case (state)
                IDLE: begin
                    if (rx_p && !rx_s) begin
                        timer   <= '0;
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_END) begin
                        timer <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PARITY: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer == BIT_END) begin
                        timer    <= '0;
                        stop_bad <= !rx_s;
                        done     <= 1'b1;
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 50 MHz / 115200 baud (434 ticks per bit).
module tb_uart_receiver;

    localparam int T = 434;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, parity_err, frame_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vcnt = 0;
    int   vcyc[$];
    exp_t sb[$];
    logic prev_v = 1'b0;

    uart_receiver #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_busy(rx_busy), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Monitor: every rx_valid pops one expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid) begin
            chk("pulse_width", {31'd0, prev_v}, 0);
            vcnt++;
            vcyc.push_back(cyc);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
            end
        end
        prev_v = rx_valid;
    end

    task automatic push(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.d  = d;
        e.pe = par ^ (^d);
        e.fe = !stp;
        sb.push_back(e);
    endtask

    // Drive the first nbits of the frame, one bit period each.
    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int nbits);
        logic [10:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = f[i];
            repeat (T) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && vcnt < target; i++) @(negedge clk);
        chk("valid_seen", {31'd0, vcnt >= target}, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, {24'd0, rx_data}, 0);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 0);
        chk({tag, "_busy"}, {31'd0, rx_busy}, 0);
        chk({tag, "_perr"}, {31'd0, parity_err}, 0);
        chk({tag, "_ferr"}, {31'd0, frame_err}, 0);
    endtask

    initial begin
        int t0, n;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // A5, good parity. Start drive -> E is 3 edges later (2 sync flops + edge copy), valid at E+4558.
        push(8'hA5, 1'b0, 1'b1);
        n = vcnt; t0 = cyc;
        send(8'hA5, 1'b0, 1'b1, 11);
        wait_valid(n + 1, 100);
        chk("a5_latency", vcyc[n] - t0, 4561);
        chk("a5_busy_after", {31'd0, rx_busy}, 0);
        repeat (20) @(negedge clk);

        // 01 with wrong parity bit
        push(8'h01, 1'b0, 1'b1);
        n = vcnt;
        send(8'h01, 1'b0, 1'b1, 11);
        wait_valid(n + 1, 100);
        repeat (20) @(negedge clk);

        // 3C with stop bit 0, then line held low
        push(8'h3C, 1'b0, 1'b0);
        n = vcnt;
        send(8'h3C, 1'b0, 1'b0, 11);
        wait_valid(n + 1, 100);
        repeat (1500) @(negedge clk);
        chk("low_line_no_valid", vcnt, n + 1);
        rx_in = 1'b1;
        repeat (50) @(negedge clk);

        // 100-cycle glitch: E = t0+3, busy drops at E+217
        n = vcnt; t0 = cyc;
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        rx_in = 1'b1;
        chk("glitch_busy_hi", {31'd0, rx_busy}, 1);
        repeat (119) @(negedge clk);
        chk("glitch_busy_e216", {31'd0, rx_busy}, 1);
        repeat (2) @(negedge clk);
        chk("glitch_busy_e218", {31'd0, rx_busy}, 0);
        repeat (500) @(negedge clk);
        chk("glitch_no_valid", vcnt, n);
        chk("glitch_data_kept", {24'd0, rx_data}, 32'h3C);
        chk("glitch_ferr_kept", {31'd0, frame_err}, 1);

        // Back-to-back 55, FF
        push(8'h55, 1'b0, 1'b1);
        push(8'hFF, 1'b0, 1'b1);
        n = vcnt;
        send(8'h55, 1'b0, 1'b1, 11);
        send(8'hFF, 1'b0, 1'b1, 11);
        wait_valid(n + 2, 200);
        if (vcnt >= n + 2) chk("b2b_gap", vcyc[n + 1] - vcyc[n], 4774);
        repeat (20) @(negedge clk);

        // Reset during the 4th data bit
        n = vcnt;
        send(8'hC3, 1'b0, 1'b1, 4);
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("midrst");
        rx_in = 1'b1;
        repeat (500) @(negedge clk);
        chk("midrst_no_valid", vcnt, n);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        chk_reset_vals("post_rel");
        push(8'h7E, 1'b0, 1'b1);
        send(8'h7E, 1'b0, 1'b1, 11);
        wait_valid(n + 1, 100);
        repeat (20) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
